c_pipe_sync_receiver: RTL and testbench

//  Clocked receiving end of the 4-phase bundled-data handshake produced by the Muller
//  C-element pipeline (muller_c_proj). Synchronises the asynchronous request, captures
//  the bundled data into a one-entry output register and returns the acknowledge.

---
 rtl/c_pipe_sync_receiver.sv | 107 ++++++++++
 tb/tb_c_pipe_sync_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/c_pipe_sync_receiver.sv
// Clocked receiver for the 4-phase bundled-data handshake of the C-element pipeline.
// Synchronises the request, captures the bundled word and returns a registered acknowledge.
module c_pipe_sync_receiver #(
  parameter int DATA_W   = 4,
  parameter int SYNC_STG = 2,
  parameter int TIMEOUT  = 255,
  parameter int CNT_W    = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              async_req_i,
  input  logic [DATA_W-1:0] async_data_i,
  output logic              async_ack_o,
  output logic              m_valid_o,
  output logic [DATA_W-1:0] m_data_o,
  input  logic              m_ready_i,
  output logic [CNT_W-1:0]  hs_count_o,
  output logic              err_timeout_o,
  output logic              busy_o
);

  // Timer is wide enough to reach TIMEOUT-1 without saturating first.
  localparam int TIMER_W = $clog2(TIMEOUT + 2);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t              state_q, state_d;
  logic [SYNC_STG-1:0] sync_q, sync_d;
  logic                ack_q, ack_d;
  logic                valid_q, valid_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;

  logic req_s;
  logic slot_free;
  logic capture;

  always_comb begin
    sync_d    = {sync_q[SYNC_STG-2:0], async_req_i};
    req_s     = sync_q[SYNC_STG-1];
    slot_free = !valid_q || m_ready_i;
    capture   = (state_q == IDLE) && req_s && slot_free;
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    timer_d = timer_q;
    // A word leaving this cycle empties the register unless a capture refills it.
    valid_d = valid_q && !m_ready_i;
    case (state_q)
      IDLE: begin
        if (capture) begin
          data_d  = async_data_i;
          valid_d = 1'b1;
          timer_d = '0;
          state_d = ACK;
        end
      end
      ACK: begin
        if (timer_q != '1) timer_d = timer_q + TIMER_W'(1);
        if (!req_s) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end else if ((TIMEOUT != 0) && (timer_q == TIMER_LAST)) begin
          err_d = 1'b1;
        end
      end
    endcase
    ack_d = (state_d == ACK);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      sync_q  <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      timer_q <= timer_d;
    end
  end

  assign async_ack_o   = ack_q;
  assign m_valid_o     = valid_q;
  assign m_data_o      = data_q;
  assign hs_count_o    = cnt_q;
  assign err_timeout_o = err_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_c_pipe_sync_receiver.sv
// Bench for c_pipe_sync_receiver: directed handshakes checked against a cycle model
// of the receiver's rules, plus literal expectations at the key edges.
module tb_c_pipe_sync_receiver;

  localparam int DW = 4;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int CW = 4;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b1;
  logic          async_req_i = 1'b1;
  logic [DW-1:0] async_data_i = '0;
  logic          async_ack_o;
  logic          m_valid_o;
  logic [DW-1:0] m_data_o;
  logic          m_ready_i = 1'b0;
  logic [CW-1:0] hs_count_o;
  logic          err_timeout_o;
  logic          busy_o;

  int n_chk = 0;
  int n_err = 0;

  c_pipe_sync_receiver #(
    .DATA_W(DW), .SYNC_STG(SS), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .async_req_i(async_req_i), .async_data_i(async_data_i), .async_ack_o(async_ack_o),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_ready_i(m_ready_i),
    .hs_count_o(hs_count_o), .err_timeout_o(err_timeout_o), .busy_o(busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Receiver model: request seen through a delay line, then the handshake rules.
  logic          msync [SS];
  logic          mack = 1'b0, mvalid = 1'b0, merr = 1'b0;
  logic [DW-1:0] mdata = '0;
  int            mcnt = 0, mtimer = 0;
  logic          rs, fr, cap;

  logic [DW-1:0] log_w [16];
  int            log_n = 0;
  logic          log_en = 1'b0;

  initial for (int i = 0; i < SS; i++) msync[i] = 1'b0;

  always @(posedge wb_clk_i) begin
    if (log_en && m_valid_o && m_ready_i) begin
      if (log_n < 16) log_w[log_n] = m_data_o;
      log_n++;
    end
    rs  = msync[SS-1];
    fr  = !mvalid || m_ready_i;
    cap = !mack && rs && fr;
    if (wb_rst_i) begin
      mack = 1'b0; mvalid = 1'b0; merr = 1'b0; mdata = '0; mcnt = 0; mtimer = 0;
      for (int i = 0; i < SS; i++) msync[i] = 1'b0;
    end else begin
      if (cap) begin
        mdata = async_data_i; mvalid = 1'b1; mack = 1'b1; mtimer = 0;
      end else begin
        if (mvalid && m_ready_i) mvalid = 1'b0;
        if (mack) begin
          if (!rs) begin
            mack = 1'b0;
            mcnt = (mcnt + 1) % (1 << CW);
          end else if (TO != 0 && mtimer == TO - 1) begin
            merr = 1'b1;
          end
          mtimer++;
        end
      end
      for (int i = SS - 1; i > 0; i--) msync[i] = msync[i-1];
      msync[0] = async_req_i;
    end
    #1;
    chk("m_ack",   async_ack_o,   mack);
    chk("m_valid", m_valid_o,     mvalid);
    chk("m_data",  m_data_o,      mdata);
    chk("m_count", hs_count_o,    mcnt);
    chk("m_err",   err_timeout_o, merr);
    chk("m_busy",  busy_o,        mack);
  end

  task automatic edges(input int n);
    repeat (n) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic wait_ack(input logic level, input string name);
    int k;
    k = 0;
    while (async_ack_o !== level && k < 20) begin
      @(posedge wb_clk_i); #1;
      k++;
    end
    chk(name, async_ack_o, level);
  endtask

  task automatic handshake(input logic [DW-1:0] d);
    @(negedge wb_clk_i);
    async_data_i = d;
    async_req_i  = 1'b1;
    wait_ack(1'b1, "hs_ack_rise");
    @(negedge wb_clk_i);
    async_req_i = 1'b0;
    wait_ack(1'b0, "hs_ack_fall");
  endtask

  initial begin
    // T1: reset held with request high
    for (int i = 0; i < 3; i++) begin
      edges(1);
      chk("t1_ack", async_ack_o, 0);
      chk("t1_valid", m_valid_o, 0);
      chk("t1_count", hs_count_o, 0);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0; async_req_i = 1'b0;
    edges(4);

    // T2: single word
    @(negedge wb_clk_i);
    async_data_i = 4'b0101; async_req_i = 1'b1; m_ready_i = 1'b1;
    edges(2);
    chk("t2_ack_e2", async_ack_o, 0);
    edges(1);
    chk("t2_ack_e3", async_ack_o, 1);
    chk("t2_valid_e3", m_valid_o, 1);
    chk("t2_data_e3", m_data_o, 4'h5);
    @(negedge wb_clk_i);
    async_req_i = 1'b0;
    edges(2);
    chk("t2_ack_held", async_ack_o, 1);
    edges(1);
    chk("t2_ack_fall", async_ack_o, 0);
    chk("t2_count", hs_count_o, 1);

    // T3: backpressure
    @(negedge wb_clk_i);
    m_ready_i = 1'b0; async_data_i = 4'h3; async_req_i = 1'b1;
    edges(3);
    chk("t3_data3", m_data_o, 4'h3);
    @(negedge wb_clk_i);
    async_req_i = 1'b0;
    edges(3);
    chk("t3_ack_fall", async_ack_o, 0);
    @(negedge wb_clk_i);
    async_data_i = 4'hA; async_req_i = 1'b1;
    edges(5);
    chk("t3_ack_withheld", async_ack_o, 0);
    chk("t3_held_valid", m_valid_o, 1);
    chk("t3_held_data", m_data_o, 4'h3);
    @(negedge wb_clk_i);
    m_ready_i = 1'b1;
    edges(1);
    chk("t3_refill_valid", m_valid_o, 1);
    chk("t3_refill_data", m_data_o, 4'hA);
    chk("t3_refill_ack", async_ack_o, 1);
    @(negedge wb_clk_i);
    async_req_i = 1'b0;
    edges(3);
    chk("t3_count", hs_count_o, 3);

    // T4: timeout
    @(negedge wb_clk_i);
    async_data_i = 4'h7; async_req_i = 1'b1;
    edges(3);
    chk("t4_ack", async_ack_o, 1);
    edges(7);
    chk("t4_err_early", err_timeout_o, 0);
    edges(1);
    chk("t4_err_set", err_timeout_o, 1);
    @(negedge wb_clk_i);
    async_req_i = 1'b0;
    edges(4);
    chk("t4_err_sticky", err_timeout_o, 1);
    chk("t4_ack_fall", async_ack_o, 0);

    // T6: reset while acknowledging with request held
    @(negedge wb_clk_i);
    async_data_i = 4'h9; async_req_i = 1'b1;
    edges(3);
    chk("t6_ack_before", async_ack_o, 1);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    edges(1);
    chk("t6_ack_dropped", async_ack_o, 0);
    chk("t6_err_cleared", err_timeout_o, 0);
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    edges(2);
    chk("t6_ack_e2", async_ack_o, 0);
    edges(1);
    chk("t6_recap_ack", async_ack_o, 1);
    chk("t6_recap_data", m_data_o, 4'h9);
    @(negedge wb_clk_i);
    async_req_i = 1'b0;
    edges(4);

    // T5: counter wrap over 16 handshakes
    @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    log_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      handshake(DW'(i));
      if (i == 7) chk("t5_count_mid", hs_count_o, 8);
    end
    edges(2);
    chk("t5_count_wrap", hs_count_o, 0);
    chk("t5_words", log_n, 16);
    for (int i = 0; i < 16; i++) chk("t5_word", log_w[i], i);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
